// File: rtl/adc_driver_pkg.sv
// Shared types for the ADC capture sequencer.
// Holds the FSM state encoding and the trigger mode constants.
package adc_driver_pkg;

    typedef enum logic [1:0] {
        PRETRIG  = 2'd0,
        ARMED    = 2'd1,
        POSTTRIG = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] MODE_NORMAL    = 2'd0;
    localparam logic [1:0] MODE_AUTO      = 2'd1;
    localparam logic [1:0] MODE_IMMEDIATE = 2'd2;

endpackage

// File: rtl/adc_driver_if.sv
// Buffer write bus plus capture hand-off to the SPI read-out.
// Ports: valid/ready handshake, mem_addr/mem_en write strobe, trig_addr.
interface adc_driver_if #(
    parameter int DEPTH = 6
) ();

    logic             valid;
    logic             ready;
    logic [DEPTH:0]   mem_addr;
    logic             mem_en;
    logic [DEPTH:0]   trig_addr;

    modport master (
        output valid,
        output mem_addr,
        output mem_en,
        output trig_addr,
        input  ready
    );

    modport slave (
        input  valid,
        input  mem_addr,
        input  mem_en,
        input  trig_addr,
        output ready
    );

endinterface

// File: rtl/adc_driver_sample_strobe_gen.sv
// Sample-rate divider: one-clock strobe every max(sample_divider,1) clocks.
// Ports: clk, rst_n, sample_divider in; strobe out (registered).
module sample_strobe_gen #(
    parameter int DEL_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEL_W-1:0] sample_divider,
    output logic             strobe
);

    logic [DEL_W-1:0] cnt;
    logic [DEL_W-1:0] reload;

    // Divider is only sampled at reload, so a change lands on the next period.
    assign reload = (sample_divider == '0) ? '0
                                           : sample_divider - DEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (cnt == '0) begin
            cnt    <= reload;
            strobe <= 1'b1;
        end else begin
            cnt    <= cnt - DEL_W'(1);
            strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_driver.sv
// Capture sequencer: pre-trigger fill, arming, post-trigger capture, hand-off.
// Ports: clk, rst_n, sample_divider, mode, trigger_req in; bus (master);
//        waiting_for_trigger, triggered out.
module adc_driver
    import adc_driver_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int DEL_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEL_W-1:0] sample_divider,
    input  logic [1:0]       mode,
    input  logic             trigger_req,
    adc_driver_if.master     bus,
    output logic             waiting_for_trigger,
    output logic             triggered
);

    localparam int H = 2 ** DEPTH;
    localparam logic [DEPTH-1:0] CNT_LAST = DEPTH'(H - 1);
    localparam logic [DEPTH+1:0] AUTO_LIM = (DEPTH+2)'(2 * H);

    state_t           state_q, state_d;
    logic [DEPTH-1:0] cnt_q, cnt_d;
    logic [DEPTH+1:0] auto_q, auto_d;
    logic [DEPTH:0]   addr_q, addr_d;
    logic [DEPTH:0]   taddr_q, taddr_d;
    logic             pend_q, pend_d;
    logic             trig_prev_q;
    logic             strobe;
    logic             rise;
    logic             wr;
    logic             pend_now;
    logic             fire;

    sample_strobe_gen #(.DEL_W(DEL_W)) u_strobe (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_divider (sample_divider),
        .strobe         (strobe)
    );

    assign rise     = trigger_req & ~trig_prev_q;
    assign wr       = strobe & (state_q != DONE);
    // An edge arriving on the trigger write itself still counts.
    assign pend_now = pend_q | rise;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        addr_d  = addr_q;
        taddr_d = taddr_q;
        pend_d  = 1'b0;
        fire    = 1'b0;

        if (wr) addr_d = addr_q + (DEPTH+1)'(1);

        unique case (1'b1)
            mode >= MODE_IMMEDIATE: fire = 1'b1;
            mode == MODE_AUTO:      fire = pend_now | (auto_q == AUTO_LIM);
            mode == MODE_NORMAL:    fire = pend_now;
            default:                fire = 1'b0;
        endcase

        unique case (state_q)
            PRETRIG: begin
                if (wr) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DEPTH'(1);
                    end
                end
            end
            ARMED: begin
                pend_d = pend_now;
                if (wr) begin
                    if (fire) begin
                        taddr_d = addr_q;
                        state_d = POSTTRIG;
                        // Trigger write is post-trigger sample 0.
                        cnt_d   = DEPTH'(1);
                        auto_d  = '0;
                        pend_d  = 1'b0;
                    end else if (auto_q != AUTO_LIM) begin
                        auto_d = auto_q + (DEPTH+2)'(1);
                    end
                end
            end
            POSTTRIG: begin
                if (wr) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DEPTH'(1);
                    end
                end
            end
            DONE: begin
                if (bus.ready) state_d = PRETRIG;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRETRIG;
            cnt_q       <= '0;
            auto_q      <= '0;
            addr_q      <= '0;
            taddr_q     <= '0;
            pend_q      <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            auto_q      <= auto_d;
            addr_q      <= addr_d;
            taddr_q     <= taddr_d;
            pend_q      <= pend_d;
            trig_prev_q <= trigger_req;
        end
    end

    assign bus.mem_addr        = addr_q;
    assign bus.mem_en          = wr;
    assign bus.trig_addr       = taddr_q;
    assign bus.valid           = (state_q == DONE);
    assign waiting_for_trigger = (state_q == ARMED);
    assign triggered           = (state_q == POSTTRIG) | (state_q == DONE);

endmodule

// File: tb/tb_adc_driver.sv
// Self-checking bench for adc_driver (DEPTH=6, DEL_W=24).
// Directed main capture sequence plus a table of divider/mode cases.
module tb_adc_driver;

    localparam int DEPTH = 6;
    localparam int DEL_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DEL_W-1:0] sample_divider;
    logic [1:0]       mode;
    logic             trigger_req;
    logic             waiting_for_trigger;
    logic             triggered;

    adc_driver_if #(.DEPTH(DEPTH)) bus ();

    adc_driver #(.DEPTH(DEPTH), .DEL_W(DEL_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sample_divider      (sample_divider),
        .mode                (mode),
        .trigger_req         (trigger_req),
        .bus                 (bus.master),
        .waiting_for_trigger (waiting_for_trigger),
        .triggered           (triggered)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int div;
        int md;
        int trig_at;
        int period;
        int taddr;
        int armed;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, bus.valid, 0);
        chk({tag, "_en"}, bus.mem_en, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_taddr"}, bus.trig_addr, 0);
        chk({tag, "_wait"}, waiting_for_trigger, 0);
        chk({tag, "_trig"}, triggered, 0);
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int  first;
        int  period;
        int  armed;
        int  post;
        bit  done;
        @(negedge clk);
        rst_n          = 1'b0;
        trigger_req    = 1'b0;
        bus.ready      = 1'b0;
        sample_divider = DEL_W'(v.div);
        mode           = 2'(v.md);
        @(negedge clk);
        rst_n  = 1'b1;
        first  = -1;
        period = -1;
        armed  = 0;
        post   = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                if (first < 0) first = cyc;
                else if (period < 0) period = cyc - first;
            end
            if (bus.valid) begin
                done = 1'b1;
            end else if (waiting_for_trigger && bus.mem_en) begin
                trigger_req = (armed == v.trig_at);
                armed++;
            end else begin
                trigger_req = 1'b0;
                if (triggered && bus.mem_en) post++;
            end
        end
        $display("case %0d: div=%0d mode=%0d", idx, v.div, v.md);
        chk("case_done", done, 1);
        chk("case_period", period, v.period);
        chk("case_taddr", bus.trig_addr, v.taddr);
        chk("case_armed", armed, v.armed);
        chk("case_post", post, 63);
        chk("case_done_en", bus.mem_en, 0);
        chk("case_done_trig", triggered, 1);
    endtask

    initial begin
        tv[0] = '{1, 0,  3, 1, 'h43,   4};
        tv[1] = '{0, 2, -1, 1, 'h40,   1};
        tv[2] = '{4, 3, -1, 4, 'h40,   1};
        tv[3] = '{1, 1, -1, 1, 'h40, 129};
        tv[4] = '{1, 1,  5, 1, 'h45,   6};
        tv[5] = '{3, 0,  0, 3, 'h40,   1};

        rst_n          = 1'b0;
        sample_divider = DEL_W'(1);
        mode           = 2'd0;
        trigger_req    = 1'b0;
        bus.ready      = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("rst");
        rst_n = 1'b1;

        // Pre-trigger fill; the trigger pulse here must be ignored.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("pre_en", bus.mem_en, 1);
            chk("pre_addr", bus.mem_addr, i);
            chk("pre_wait", waiting_for_trigger, 0);
            trigger_req = (i >= 10 && i < 13);
        end

        // Armed: addresses wrap 127 -> 0, stop on the 0x25 write.
        for (int k = 0; k < 102; k++) begin
            @(negedge clk);
            chk("arm_addr", bus.mem_addr, (64 + k) % 128);
            chk("arm_wait", waiting_for_trigger, 1);
            chk("arm_trig", triggered, 0);
        end
        trigger_req = 1'b1;
        @(negedge clk);
        chk("hit_taddr", bus.trig_addr, 'h25);
        chk("hit_trig", triggered, 1);
        chk("hit_wait", waiting_for_trigger, 0);
        chk("hit_addr", bus.mem_addr, 'h26);
        trigger_req = 1'b0;

        for (int k = 2; k < 64; k++) begin
            @(negedge clk);
            chk("post_addr", bus.mem_addr, 'h25 + k);
            chk("post_en", bus.mem_en, 1);
            chk("post_valid", bus.valid, 0);
        end

        // DONE with ready low; trigger edges here are ignored.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("done_valid", bus.valid, 1);
            chk("done_en", bus.mem_en, 0);
            chk("done_addr", bus.mem_addr, 'h65);
            chk("done_taddr", bus.trig_addr, 'h25);
            trigger_req = (i % 4 == 1);
        end

        // Ready together with a trigger edge: restart, edge ignored.
        bus.ready   = 1'b1;
        trigger_req = 1'b1;
        @(negedge clk);
        chk("rel_valid", bus.valid, 0);
        chk("rel_trig", triggered, 0);
        chk("rel_wait", waiting_for_trigger, 0);
        chk("rel_en", bus.mem_en, 1);
        chk("rel_addr", bus.mem_addr, 'h65);
        bus.ready   = 1'b0;
        trigger_req = 1'b0;
        @(negedge clk);
        chk("rel_addr2", bus.mem_addr, 'h66);
        chk("rel_taddr", bus.trig_addr, 'h25);

        for (int i = 0; i < 6; i++) run_case(i, tv[i]);

        // Asynchronous reset in the middle of POSTTRIG.
        @(negedge clk);
        rst_n          = 1'b0;
        sample_divider = DEL_W'(1);
        mode           = 2'd2;
        trigger_req    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (triggered) break;
        end
        chk("abort_reached", triggered, 1);
        repeat (5) @(negedge clk);
        chk("abort_pre_en", bus.mem_en, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
